// File: rtl/nios_cpu_pio_ext.sv
`default_nettype none
// ============================================================================
//  Module      : nios_cpu_pio_ext
//  Description : Memory-mapped parallel I/O port with per-bit direction,
//                atomic set/clear of the output data, a 2-flop input
//                synchronizer and optional edge capture with masked irq.
//                Define NIOS_CPU_PIO_EXT_EDGE_IRQ_EN to compile in edge
//                capture, irq mask, priming counter and irq.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios_cpu_pio_ext #(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter logic [31:0] DIR_RESET   = 32'h0,
    parameter int          EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] c_addr_data   = 3'd0;
    localparam logic [2:0] c_addr_dir    = 3'd1;
    localparam logic [2:0] c_addr_mask   = 3'd2;
    localparam logic [2:0] c_addr_cap    = 3'd3;
    localparam logic [2:0] c_addr_outset = 3'd4;
    localparam logic [2:0] c_addr_outclr = 3'd5;

    localparam logic [WIDTH-1:0] c_data_rst = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_dir_rst  = DIR_RESET[WIDTH-1:0];

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_capture;
    logic [WIDTH-1:0] w_rd;

    assign w_wr     = chipselect & ~write_n;
    assign w_wd     = writedata[WIDTH-1:0];
    assign out_port = r_data;
    assign oe       = r_dir;

    // Output data and direction registers, including atomic set/clear aliases
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= c_data_rst;
            r_dir  <= c_dir_rst;
        end else if (w_wr) begin
            case (address)
                c_addr_data:   r_data <= w_wd;
                c_addr_dir:    r_dir  <= w_wd;
                c_addr_outset: r_data <= r_data | w_wd;
                c_addr_outclr: r_data <= r_data & ~w_wd;
                default:       ;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous input pins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef NIOS_CPU_PIO_EXT_EDGE_IRQ_EN
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_capture;
    logic [1:0]       r_prime;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;

    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign w_edge = r_sync2 & ~r_prev;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge = ~r_sync2 & r_prev;
        end else begin : g_edge_any
            assign w_edge = r_sync2 ^ r_prev;
        end
    endgenerate

    // Edges are ignored until the synchronizer and delay stage hold real data,
    // and only input-direction bits can capture.
    assign w_set = (r_prime == 2'd3) ? (w_edge & ~r_dir) : '0;
    assign w_clr = (w_wr && address == c_addr_cap) ? w_wd : '0;

    // Delay stage, priming counter, irq mask and sticky capture (set wins over clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev    <= '0;
            r_prime   <= 2'd0;
            r_mask    <= '0;
            r_capture <= '0;
        end else begin
            r_prev <= r_sync2;
            if (r_prime != 2'd3) begin
                r_prime <= r_prime + 2'd1;
            end
            if (w_wr && address == c_addr_mask) begin
                r_mask <= w_wd;
            end
            r_capture <= (r_capture & ~w_clr) | w_set;
        end
    end

    assign w_mask    = r_mask;
    assign w_capture = r_capture;
    assign irq       = |(r_capture & r_mask);
`else
    assign w_mask    = '0;
    assign w_capture = '0;
    assign irq       = 1'b0;
`endif

    // Zero-wait register read mux
    always_comb begin
        w_rd = '0;
        case (address)
            c_addr_data: w_rd = (r_dir & r_data) | (~r_dir & r_sync2);
            c_addr_dir:  w_rd = r_dir;
            c_addr_mask: w_rd = w_mask;
            c_addr_cap:  w_rd = w_capture;
            default:     w_rd = '0;
        endcase
    end

    generate
        if (WIDTH < 32) begin : g_pad
            logic w_unused_wd_hi;
            assign w_unused_wd_hi = |writedata[31:WIDTH];
            assign readdata       = {{(32-WIDTH){1'b0}}, w_rd};
        end else begin : g_full
            assign readdata = w_rd;
        end
    endgenerate

endmodule
`default_nettype wire
